// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter
//   Shares the register-file write port among N_REQ writeback requesters.
//   A round-robin arbiter accepts at most one request per cycle. The accepted
//   request is registered into a one-entry write stage, which drives the
//   register file. Two forwarding lookups expose the staged write so that
//   readers see it one cycle before the register file holds it.
//
// Ports
//   clk, clr                 clock, synchronous active-high clear
//   req_valid[N_REQ]         requester i has a write pending
//   req_number[5*N_REQ]      destination register of requester i
//   req_data[32*N_REQ]       write data of requester i
//   req_ready[N_REQ]         combinational one-hot grant (or zero)
//   hold                     blocks new grants; the write stage still drains
//   w_en, w_number, data_in  registered write stage towards the register file
//   fwd_number_a/b           forwarding lookup addresses
//   fwd_hit_a/b, fwd_data_a/b  forwarding results (data is 0 on a miss)
//
// Handshake: a transfer from requester i happens at a rising edge where
// req_valid[i] and req_ready[i] are both high. The requester must keep
// req_number/req_data stable while valid is high and not yet accepted.
// req_ready never depends on req_number/req_data.

module regfile_wport_arbiter #(
  parameter int N_REQ = 3
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [5*N_REQ-1:0]    req_number,
  input  logic [32*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  input  logic                  hold,
  output logic                  w_en,
  output logic [4:0]            w_number,
  output logic [31:0]           data_in,
  input  logic [4:0]            fwd_number_a,
  input  logic [4:0]            fwd_number_b,
  output logic                  fwd_hit_a,
  output logic                  fwd_hit_b,
  output logic [31:0]           fwd_data_a,
  output logic [31:0]           fwd_data_b
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] next_ptr;
  logic             grant_any;
  logic [4:0]       grant_number;
  logic [31:0]      grant_data;
  int               scan_idx;

  // Round-robin search: start at ptr, walk upward with wrap-around, first
  // valid requester wins. The winner's number/data are muxed out here so the
  // sequential block only has to register them.
  always_comb begin
    req_ready    = '0;
    grant_any    = 1'b0;
    grant_idx    = '0;
    grant_number = '0;
    grant_data   = '0;
    scan_idx     = 0;
    if (!clr && !hold) begin
      for (int k = 0; k < N_REQ; k++) begin
        scan_idx = int'(ptr) + k;
        if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
        if (!grant_any && req_valid[scan_idx]) begin
          grant_any          = 1'b1;
          grant_idx          = scan_idx[PTR_W-1:0];
          grant_number       = req_number[5*scan_idx +: 5];
          grant_data         = req_data[32*scan_idx +: 32];
          req_ready[scan_idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (grant_idx == PTR_W'(N_REQ - 1)) next_ptr = '0;
    else                                next_ptr = grant_idx + PTR_W'(1);
  end

  // Write stage. A write to register 0 still consumes its grant and moves
  // the pointer, but is never presented to the register file.
  always_ff @(posedge clk) begin
    if (clr) begin
      ptr      <= '0;
      w_en     <= 1'b0;
      w_number <= '0;
      data_in  <= '0;
    end else if (grant_any) begin
      ptr      <= next_ptr;
      w_en     <= (grant_number != 5'd0);
      w_number <= grant_number;
      data_in  <= grant_data;
    end else begin
      w_en     <= 1'b0;
    end
  end

  // Forwarding: register 0 never hits, so a lookup of r0 always reads 0.
  always_comb begin
    fwd_hit_a  = w_en && (w_number == fwd_number_a) && (fwd_number_a != 5'd0);
    fwd_hit_b  = w_en && (w_number == fwd_number_b) && (fwd_number_b != 5'd0);
    fwd_data_a = fwd_hit_a ? data_in : 32'd0;
    fwd_data_b = fwd_hit_b ? data_in : 32'd0;
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Testbench for regfile_wport_arbiter (N_REQ = 3).
//   Directed stimulus with literal expectations, plus a per-cycle compare
//   against a behavioural model and a scoreboard of expected register writes.

module tb_regfile_wport_arbiter;

  localparam int N = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              clr;
  logic [N-1:0]      req_valid;
  logic [5*N-1:0]    req_number;
  logic [32*N-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              hold;
  logic              w_en;
  logic [4:0]        w_number;
  logic [31:0]       data_in;
  logic [4:0]        fwd_number_a, fwd_number_b;
  logic              fwd_hit_a, fwd_hit_b;
  logic [31:0]       fwd_data_a, fwd_data_b;

  regfile_wport_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_number(req_number), .req_data(req_data),
    .req_ready(req_ready), .hold(hold),
    .w_en(w_en), .w_number(w_number), .data_in(data_in),
    .fwd_number_a(fwd_number_a), .fwd_number_b(fwd_number_b),
    .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard + behavioural model ----------------
  // Expected register-file writes, {number, data}, in order of acceptance.
  logic [36:0] exp_q[$];

  int          m_ptr;
  logic        m_wen;
  logic [4:0]  m_wnum;
  logic [31:0] m_data;

  initial begin
    int g;
    logic [N-1:0] exp_ready;
    logic [36:0] ent;
    m_ptr = 0; m_wen = 1'b0; m_wnum = '0; m_data = '0;
    @(posedge clk);  // first edge happens with clr high
    forever begin
      @(negedge clk);
      // expected grant: first valid requester at or after m_ptr (mod N)
      g = -1;
      exp_ready = '0;
      if (!clr && !hold)
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      if (g >= 0) exp_ready[g] = 1'b1;

      check("m_req_ready", 32'(req_ready), 32'(exp_ready));
      check("m_w_en",      32'(w_en),      32'(m_wen));
      check("m_w_number",  32'(w_number),  32'(m_wnum));
      check("m_data_in",   data_in,        m_data);
      check("m_fwd_hit_a", 32'(fwd_hit_a),
            32'(m_wen && m_wnum == fwd_number_a && fwd_number_a != 0));
      check("m_fwd_hit_b", 32'(fwd_hit_b),
            32'(m_wen && m_wnum == fwd_number_b && fwd_number_b != 0));
      check("m_fwd_data_a", fwd_data_a,
            (m_wen && m_wnum == fwd_number_a && fwd_number_a != 0) ? m_data : 32'd0);
      check("m_fwd_data_b", fwd_data_b,
            (m_wen && m_wnum == fwd_number_b && fwd_number_b != 0) ? m_data : 32'd0);

      if (w_en === 1'b1) begin
        if (exp_q.size() == 0) check("sb_unexpected_write", 32'(w_number), 32'h0);
        else begin
          ent = exp_q.pop_front();
          check("sb_write", {w_number, data_in[26:0]}, {ent[36:32], ent[26:0]});
          check("sb_write_data", data_in, ent[31:0]);
        end
      end

      // advance the model to the state after the coming edge
      if (clr) begin
        m_ptr = 0; m_wen = 1'b0; m_wnum = '0; m_data = '0;
      end else if (g >= 0) begin
        m_ptr  = (g + 1) % N;
        m_wnum = req_number[5*g +: 5];
        m_data = req_data[32*g +: 32];
        m_wen  = (m_wnum != 5'd0);
        if (m_wen) exp_q.push_back({m_wnum, m_data});
      end else begin
        m_wen = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_default_reqs();
    req_number = {5'd3, 5'd2, 5'd1};
    req_data   = {32'hC0, 32'hB0, 32'hA0};
  endtask

  initial begin
    clr = 1'b1; hold = 1'b0; req_valid = '1;
    fwd_number_a = '0; fwd_number_b = '0;
    set_default_reqs();

    // reset: clr held two edges with all requesters valid
    step();
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_w_en", 32'(w_en), 32'h0);
    step();
    check("rst_w_en2", 32'(w_en), 32'h0);
    check("rst_w_number", 32'(w_number), 32'h0);
    check("rst_data_in", data_in, 32'h0);
    clr = 1'b0; settle();
    check("first_grant", 32'(req_ready), 32'b001);

    // round-robin rotation: 0,1,2,0
    step();
    check("rr0_num", 32'(w_number), 32'd1); check("rr0_data", data_in, 32'hA0);
    check("rr0_w_en", 32'(w_en), 32'd1);    check("rr1_ready", 32'(req_ready), 32'b010);
    step();
    check("rr1_num", 32'(w_number), 32'd2); check("rr1_data", data_in, 32'hB0);
    check("rr2_ready", 32'(req_ready), 32'b100);
    step();
    check("rr2_num", 32'(w_number), 32'd3); check("rr2_data", data_in, 32'hC0);
    check("rr3_ready", 32'(req_ready), 32'b001);
    step();
    check("rr3_num", 32'(w_number), 32'd1); check("rr3_data", data_in, 32'hA0);

    // idle edge: write stage empties, ptr stays 1
    req_valid = '0; step();
    check("idle_w_en", 32'(w_en), 32'd0);

    // sparse: requester 2, then requester 1
    req_valid = 3'b100; settle();
    check("sparse2_ready", 32'(req_ready), 32'b100);
    step();
    check("sparse2_num", 32'(w_number), 32'd3);
    req_valid = 3'b010; settle();
    check("sparse1_ready", 32'(req_ready), 32'b010);  // ptr now 0
    step();
    check("sparse1_num", 32'(w_number), 32'd2);
    req_valid = 3'b101; settle();
    check("ptr_is_2", 32'(req_ready), 32'b100);
    req_valid = '0; step();

    // write to register 0 (ptr = 2, wraps to requester 0)
    req_number[4:0] = 5'd0; req_data[31:0] = 32'h1234;
    req_valid = 3'b001; fwd_number_a = 5'd0; settle();
    check("r0_ready", 32'(req_ready), 32'b001);
    step();
    check("r0_w_en", 32'(w_en), 32'd0);
    check("r0_hit_a", 32'(fwd_hit_a), 32'd0);
    check("r0_fwd_data_a", fwd_data_a, 32'd0);
    check("r0_data_in", data_in, 32'h1234);
    req_valid = 3'b011; settle();
    check("r0_ptr_adv", 32'(req_ready), 32'b010);
    req_valid = '0;

    // forwarding: 0xDEADBEEF to r7 via requester 1
    req_number[9:5] = 5'd7; req_data[63:32] = 32'hDEADBEEF;
    req_valid = 3'b010; step();
    req_valid = '0; fwd_number_a = 5'd7; fwd_number_b = 5'd8; settle();
    check("fwd_hit_a", 32'(fwd_hit_a), 32'd1);
    check("fwd_data_a", fwd_data_a, 32'hDEADBEEF);
    check("fwd_hit_b", 32'(fwd_hit_b), 32'd0);
    check("fwd_data_b", fwd_data_b, 32'd0);

    // hold and clr mid-operation (ptr = 2 here)
    set_default_reqs(); fwd_number_a = '0; fwd_number_b = '0;
    req_valid = '1;
    step();  // grant 2 -> ptr 0
    step();  // grant 0 -> ptr 1
    hold = 1'b1; settle();
    check("hold_ready", 32'(req_ready), 32'h0);
    check("hold_staged", 32'(w_en), 32'd1);
    step();
    check("hold_w_en1", 32'(w_en), 32'd0);
    step();
    check("hold_w_en2", 32'(w_en), 32'd0);
    hold = 1'b0; settle();
    check("hold_ptr_kept", 32'(req_ready), 32'b010);
    step();  // grant 1 staged
    clr = 1'b1; settle();
    check("clr_ready", 32'(req_ready), 32'h0);
    check("clr_stage_shown", 32'(w_en), 32'd1);
    step();
    clr = 1'b0;
    check("clr_w_en", 32'(w_en), 32'd0);
    check("clr_w_number", 32'(w_number), 32'd0);
    check("clr_data_in", data_in, 32'd0);
    settle();
    check("clr_ptr0", 32'(req_ready), 32'b001);

    req_valid = '0;
    step(); step(); step();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
